sd_card_detect: RTL and testbench

Card-detect and write-protect front end for the SD host controller. It synchronises the raw card-detect and write-protect pins and debounces card detect. It also provides the card-detect test-level override from Host Control 1. It drives the Present State fields card_inserted, card_state_stable, card_detect_pin_level and write_protect_switch_pin_level, plus the card insertion/removal interrupt-status set pulses, which the top level currently ties to constants.

---
 rtl/sdhci_cd_pkg.sv | 14 +
 rtl/sd_card_detect_if.sv | 39 +++
 rtl/sd_level_debounce.sv | 114 +++++++++++
 rtl/sd_card_detect.sv | 82 ++++++++
 tb/tb_sd_card_detect.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/sdhci_cd_pkg.sv
// Shared definitions for the SD host card-detect / write-protect front end.
package sdhci_cd_pkg;

   // Debouncer state: no stable value yet, settled, or timing a candidate.
   typedef enum logic [1:0] {
      INIT     = 2'd0,
      STABLE   = 2'd1,
      DEBOUNCE = 2'd2
   } cd_state_e;

   // Default hold time of the card-detect level, in clk cycles.
   localparam int unsigned SdCdDebounceDefault = 32'd65536;

endpackage : sdhci_cd_pkg

// File: rtl/sd_card_detect_if.sv
// Host-register side of the card-detect front end: the Host Control 1
// card-detect controls in, the Present State fields and the interrupt-status
// set pulses out.
interface sd_card_detect_if;

   logic cd_signal_select;        // 1 = use cd_test_level instead of the pin
   logic cd_test_level;           // 1 = card present
   logic card_inserted;           // debounced state, 1 = inserted
   logic card_state_stable;       // 1 = no debounce in progress
   logic card_detect_pin_level;   // selected, undebounced level, 1 = present
   logic write_protect_pin_level; // synchronised WP pin
   logic card_insertion;          // one-cycle insertion status set pulse
   logic card_removal;            // one-cycle removal status set pulse

   // Host controller register block.
   modport master (
      output cd_signal_select,
      output cd_test_level,
      input  card_inserted,
      input  card_state_stable,
      input  card_detect_pin_level,
      input  write_protect_pin_level,
      input  card_insertion,
      input  card_removal
   );

   // Card-detect front end.
   modport slave (
      input  cd_signal_select,
      input  cd_test_level,
      output card_inserted,
      output card_state_stable,
      output card_detect_pin_level,
      output write_protect_pin_level,
      output card_insertion,
      output card_removal
   );

endinterface : sd_card_detect_if

// File: rtl/sd_level_debounce.sv
// Generic 1-bit debouncer: a level must hold for DebounceCycles cycles before
// it becomes the stable value. Emits one-cycle rise/fall pulses when the
// stable value changes (and a rise pulse when the first stable value is 1).
module sd_level_debounce
   import sdhci_cd_pkg::*;
#(
   parameter int unsigned DebounceCycles = SdCdDebounceDefault,
   parameter int unsigned CntWidth       = $clog2(DebounceCycles)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic level,
   output logic stable_value,
   output logic stable_flag,
   output logic rise_pulse,
   output logic fall_pulse
);

   // The counter reaches CntMax on the edge that completes the hold time, so
   // the terminal decision is taken while it still reads CntLast.
   localparam logic [CntWidth-1:0] CntMax  = CntWidth'(DebounceCycles - 32'd1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 32'd2);
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(32'd1);

   cd_state_e             state_r, state_s;
   logic [CntWidth-1:0]   cnt_r, cnt_s;
   logic                  cand_r, cand_s;
   logic                  value_r, value_s;
   logic                  flag_r;
   logic                  rise_r, rise_s;
   logic                  fall_r, fall_s;
   logic                  hold_done_s;

   // Next-state logic: candidate tracking, saturating counter and FSM.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      cand_s      = cand_r;
      value_s     = value_r;
      rise_s      = 1'b0;
      fall_s      = 1'b0;
      hold_done_s = (level == cand_r) && (cnt_r == CntLast);

      if (level != cand_r) begin
         cnt_s  = '0;
         cand_s = level;
      end else if (cnt_r != CntMax) begin
         cnt_s = cnt_r + CntOne;
      end else begin
         cnt_s = cnt_r;
      end

      case (state_r)
         INIT: begin
            if (hold_done_s) begin
               state_s = STABLE;
               value_s = cand_r;
               rise_s  = cand_r;
            end else begin
               state_s = INIT;
            end
         end
         STABLE: begin
            // In STABLE the candidate equals the stable value, so a differing
            // level has already cleared the counter above.
            if (level != value_r) begin
               state_s = DEBOUNCE;
            end else begin
               state_s = STABLE;
            end
         end
         DEBOUNCE: begin
            if (hold_done_s) begin
               state_s = STABLE;
               value_s = cand_r;
               rise_s  = cand_r & ~value_r;
               fall_s  = ~cand_r & value_r;
            end else begin
               state_s = DEBOUNCE;
            end
         end
         default: begin
            state_s = INIT;
         end
      endcase
   end

   // State, counter and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r <= INIT;
         cnt_r   <= '0;
         cand_r  <= 1'b0;
         value_r <= 1'b0;
         flag_r  <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         cand_r  <= cand_s;
         value_r <= value_s;
         flag_r  <= (state_s == STABLE);
         rise_r  <= rise_s;
         fall_r  <= fall_s;
      end
   end

   assign stable_value = value_r;
   assign stable_flag  = flag_r;
   assign rise_pulse   = rise_r;
   assign fall_pulse   = fall_r;

endmodule : sd_level_debounce

// File: rtl/sd_card_detect.sv
// Card-detect and write-protect front end: pin synchronisers, Host Control 1
// test-level override, card-detect debounce and insertion/removal pulses.
module sd_card_detect
   import sdhci_cd_pkg::*;
#(
   parameter int unsigned DebounceCycles = SdCdDebounceDefault,
   parameter int unsigned CntWidth       = $clog2(DebounceCycles)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            card_detect_ni,
   input  logic            write_protect_i,
   sd_card_detect_if.slave host
);

   // The CD pin is inverted before the first flop so the synchroniser carries
   // presence; its reset value 0 then reads as "no card".
   logic present_meta_r;
   logic present_sync_r;
   logic wp_meta_r;
   logic wp_sync_r;
   logic pin_level_r;
   logic sel_level_s;
   logic stable_value_s;
   logic stable_flag_s;
   logic insertion_s;
   logic removal_s;

   // Two-flop synchronisers for the CD and WP pins.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         present_meta_r <= 1'b0;
         present_sync_r <= 1'b0;
         wp_meta_r      <= 1'b0;
         wp_sync_r      <= 1'b0;
      end else begin
         present_meta_r <= ~card_detect_ni;
         present_sync_r <= present_meta_r;
         wp_meta_r      <= write_protect_i;
         wp_sync_r      <= wp_meta_r;
      end
   end

   // Select between the synchronised pin and the host test level.
   always_comb begin
      if (host.cd_signal_select) begin
         sel_level_s = host.cd_test_level;
      end else begin
         sel_level_s = present_sync_r;
      end
   end

   // Undebounced card-detect level as seen by Present State.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pin_level_r <= 1'b0;
      end else begin
         pin_level_r <= sel_level_s;
      end
   end

   sd_level_debounce #(
      .DebounceCycles (DebounceCycles),
      .CntWidth       (CntWidth)
   ) u_debounce (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .level        (sel_level_s),
      .stable_value (stable_value_s),
      .stable_flag  (stable_flag_s),
      .rise_pulse   (insertion_s),
      .fall_pulse   (removal_s)
   );

   assign host.card_inserted           = stable_value_s;
   assign host.card_state_stable       = stable_flag_s;
   assign host.card_detect_pin_level   = pin_level_r;
   assign host.write_protect_pin_level = wp_sync_r;
   assign host.card_insertion          = insertion_s;
   assign host.card_removal            = removal_s;

endmodule : sd_card_detect

// File: tb/tb_sd_card_detect.sv
// Directed bench for sd_card_detect with DebounceCycles = 8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// "cycle c" means the outputs right after edge c of a scenario.
module tb_sd_card_detect;

   logic clk = 1'b0;
   logic rst_ni;
   logic card_detect_ni;
   logic write_protect_i;
   int   errors = 0;
   int   checks = 0;

   sd_card_detect_if cd_bus ();

   sd_card_detect #(
      .DebounceCycles (8)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .card_detect_ni  (card_detect_ni),
      .write_protect_i (write_protect_i),
      .host            (cd_bus)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string scen, input int c, input logic e_pin,
                            input logic e_ins, input logic e_stab,
                            input logic e_insp, input logic e_remp);
      check_bit($sformatf("%s c%0d pin_level", scen, c), cd_bus.card_detect_pin_level, e_pin);
      check_bit($sformatf("%s c%0d inserted", scen, c), cd_bus.card_inserted, e_ins);
      check_bit($sformatf("%s c%0d stable", scen, c), cd_bus.card_state_stable, e_stab);
      check_bit($sformatf("%s c%0d insertion", scen, c), cd_bus.card_insertion, e_insp);
      check_bit($sformatf("%s c%0d removal", scen, c), cd_bus.card_removal, e_remp);
   endtask

   // Card present, reset released just before edge 1: pin level at 3,
   // debounced insertion at 2 + 8 = 10.
   task automatic powerup_check(input string scen);
      for (int k = 1; k <= 12; k++) begin
         step();
         check_all(scen, k, k >= 3, k >= 10, k >= 10, k == 10, 1'b0);
      end
   endtask

   // Raw CD value driven after cycle j of the glitch scenario.
   function automatic logic cd_glitch(input int j);
      return (j >= 0) && (j < 5);
   endfunction

   // Raw CD value driven after cycle j of the bouncy removal scenario.
   function automatic logic cd_bouncy(input int j);
      if (j < 0) begin
         return 1'b0;
      end else if (j < 30) begin
         return ((j / 3) % 2) == 0;
      end else begin
         return 1'b1;
      end
   endfunction

   function automatic logic wp_at(input int j, input logic [11:0] pat);
      if (j < 0) begin
         return 1'b0;
      end else if (j < 12) begin
         return pat[j];
      end else begin
         return pat[11];
      end
   endfunction

   initial begin
      logic [11:0] wp_pat;
      wp_pat = 12'b1011_0011_1010;

      rst_ni                  = 1'b0;
      card_detect_ni          = 1'b0;
      write_protect_i         = 1'b0;
      cd_bus.cd_signal_select = 1'b0;
      cd_bus.cd_test_level    = 1'b0;

      // Reset state
      repeat (3) step();
      check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_bit("reset wp_level", cd_bus.write_protect_pin_level, 1'b0);

      // Power-up with card present
      rst_ni = 1'b1;
      powerup_check("powerup");

      // Glitch: CD high for 5 cycles, level back at cycle 7, stable again at 15
      for (int c = 1; c <= 18; c++) begin
         card_detect_ni = cd_glitch(c - 1);
         step();
         check_all("glitch", c, ~cd_glitch(c - 3), 1'b1,
                   !(c >= 3 && c < 15), 1'b0, 1'b0);
      end

      // Test override: level 0 from edge 1 -> removal at 8; select cleared
      // after cycle 12 -> pin level back at 13, insertion at 20
      for (int c = 1; c <= 24; c++) begin
         cd_bus.cd_signal_select = (c - 1) < 12;
         cd_bus.cd_test_level    = 1'b0;
         step();
         check_all("override", c, !(c >= 1 && c < 13), (c < 8) || (c >= 20),
                   !((c >= 1 && c < 8) || (c >= 13 && c < 20)), c == 20, c == 8);
      end

      // Bouncy removal: last edge driven after cycle 30, synchronised at 32,
      // removal at 40
      for (int c = 1; c <= 45; c++) begin
         card_detect_ni = cd_bouncy(c - 1);
         step();
         check_all("bouncy", c, ~cd_bouncy(c - 3), c < 40,
                   !(c >= 3 && c < 40), 1'b0, c == 40);
      end

      // Reset mid-debounce: insert, DEBOUNCE from cycle 3, reset on edge 7
      for (int c = 1; c <= 7; c++) begin
         card_detect_ni = 1'b0;
         rst_ni         = (c - 1) != 6;
         step();
         if (c < 7) begin
            check_all("rst_mid", c, c >= 3, 1'b0, c < 3, 1'b0, 1'b0);
         end else begin
            check_all("rst_mid", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
      rst_ni = 1'b1;
      powerup_check("rst_recover");

      // Write protect: synchronised level follows the pin 2 cycles later
      for (int c = 1; c <= 14; c++) begin
         write_protect_i = wp_at(c - 1, wp_pat);
         step();
         check_bit($sformatf("wp c%0d level", c), cd_bus.write_protect_pin_level,
                   wp_at(c - 2, wp_pat));
         check_bit($sformatf("wp c%0d inserted", c), cd_bus.card_inserted, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sd_card_detect
